aes_byte_stream_host: RTL and testbench

Host-side controller for the byte-serial `aes_8_bit` encryption core. It accepts a 128-bit key and a 128-bit plaintext block over a valid/ready handshake and holds the core in reset between blocks. It streams key and plaintext into the core one byte per cycle, waits for the core's `d_vld`, and collects the 16 ciphertext bytes into a 128-bit result. The result is returned over a second valid/ready handshake. The block sits between the user/shell logic and the AES core.

---
 rtl/aes_stream_pkg.sv | 15 +
 rtl/aes_byte_shreg.sv | 27 ++
 rtl/aes_byte_stream_host.sv | 133 +++++++++++++
 tb/tb_aes_byte_stream_host.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared types and sizes for the byte-serial AES host controller.
package aes_stream_pkg;
    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BLOCK_BITS  = AES_BLOCK_BYTES * 8;
    localparam int BYTE_CNT_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SKIP,
        S_COLLECT,
        S_DONE
    } state_e;
endpackage

// File: rtl/aes_byte_shreg.sv
// 128-bit byte shift register: parallel load, shifts left one byte at a time,
// new byte enters at the LSB end so the MSB byte is the serial output.
module aes_byte_shreg
    import aes_stream_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_load,
    input  logic [AES_BLOCK_BITS-1:0] i_data,
    input  logic                      i_shift,
    input  logic [7:0]                i_byte,
    output logic [AES_BLOCK_BITS-1:0] o_data
);
    logic [AES_BLOCK_BITS-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {r_data[AES_BLOCK_BITS-9:0], i_byte};
        end
    end

    assign o_data = r_data;
endmodule

// File: rtl/aes_byte_stream_host.sv
// Host controller for the byte-serial aes_8_bit core: streams key/plaintext in,
// waits for d_vld, gathers 16 ciphertext bytes and hands back a 128-bit result.
module aes_byte_stream_host
    import aes_stream_pkg::*;
#(
    parameter int CAPTURE_DLY = 1,
    parameter int TIMEOUT     = 512
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_key,
    input  logic [127:0] i_pt,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_ct,
    output logic         o_err,
    output logic         o_busy,
    output logic         o_core_rst,
    output logic [7:0]   o_core_key,
    output logic [7:0]   o_core_din,
    input  logic [7:0]   i_core_dout,
    input  logic         i_core_dvld
);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(AES_BLOCK_BYTES - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_e                r_state, w_state_nxt;
    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [TMO_W-1:0]      r_tmo;
    logic [3:0]            r_dly;
    logic                  r_err, r_core_rst;
    logic                  w_timeout, w_accept;
    logic [127:0]          w_key_sr, w_pt_sr;
    logic                  w_unused_lsbs;

    assign w_accept = i_in_valid && (r_state == S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE:    if (i_in_valid) w_state_nxt = S_LOAD;
            S_LOAD:    if (r_cnt == LAST_BYTE) w_state_nxt = S_WAIT;
            S_WAIT: begin
                // dvld is only looked at here, so anything it does during LOAD is ignored
                if (i_core_dvld) begin
                    w_state_nxt = (CAPTURE_DLY == 1) ? S_COLLECT : S_SKIP;
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SKIP:    if (r_dly <= 4'd1) w_state_nxt = S_COLLECT;
            S_COLLECT: if (r_cnt == LAST_BYTE) w_state_nxt = S_DONE;
            S_DONE:    if (i_out_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_dly      <= '0;
            r_err      <= 1'b0;
            r_core_rst <= 1'b1;
        end else begin
            r_err      <= w_timeout;
            // Core leaves reset on the accept edge, so it sees byte 0 in the first LOAD cycle
            r_core_rst <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
            r_tmo      <= (r_state == S_WAIT) ? r_tmo + 1'b1 : '0;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_LOAD || r_state == S_COLLECT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                r_dly <= 4'(CAPTURE_DLY - 1);
            end else if (r_state == S_SKIP) begin
                r_dly <= r_dly - 1'b1;
            end
        end
    end

    // Zeros shift in behind the data, so the MSB byte is already 0 once LOAD is over
    aes_byte_shreg u_key_sr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_accept),
        .i_data  (i_key),
        .i_shift (r_state == S_LOAD),
        .i_byte  (8'h00),
        .o_data  (w_key_sr)
    );

    aes_byte_shreg u_pt_sr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_accept),
        .i_data  (i_pt),
        .i_shift (r_state == S_LOAD),
        .i_byte  (8'h00),
        .o_data  (w_pt_sr)
    );

    aes_byte_shreg u_ct_sr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (1'b0),
        .i_data  ('0),
        .i_shift (r_state == S_COLLECT),
        .i_byte  (i_core_dout),
        .o_data  (o_ct)
    );

    assign w_unused_lsbs = ^{w_key_sr[119:0], w_pt_sr[119:0]};

    assign o_core_key  = w_key_sr[127:120];
    assign o_core_din  = w_pt_sr[127:120];
    assign o_in_ready  = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_err       = r_err;
    assign o_core_rst  = r_core_rst;
endmodule

// File: tb/tb_aes_byte_stream_host.sv
// Directed bench: two hosts (CAPTURE_DLY 1 with TIMEOUT 20, CAPTURE_DLY 3) each
// driving a known-answer stub core that records the streamed bytes.
module tb_aes_byte_stream_host;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] SW_CT  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam int DV_AT = 19;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] in_valid, out_ready, in_ready, out_valid, err, busy, core_rst, dvld;
    logic [1:0] no_dvld, glitch;
    logic [1:0][127:0] key, pt, ct;
    logic [1:0][7:0] core_key, core_din, dout;
    int scnt [2];
    logic [127:0] kcap [2];
    logic [127:0] pcap [2];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_byte_stream_host #(.CAPTURE_DLY(1), .TIMEOUT(20)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_key(key[0]), .i_pt(pt[0]), .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]),
        .o_ct(ct[0]), .o_err(err[0]), .o_busy(busy[0]), .o_core_rst(core_rst[0]),
        .o_core_key(core_key[0]), .o_core_din(core_din[0]), .i_core_dout(dout[0]),
        .i_core_dvld(dvld[0])
    );

    aes_byte_stream_host #(.CAPTURE_DLY(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_key(key[1]), .i_pt(pt[1]), .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]),
        .o_ct(ct[1]), .o_err(err[1]), .o_busy(busy[1]), .o_core_rst(core_rst[1]),
        .o_core_key(core_key[1]), .o_core_din(core_din[1]), .i_core_dout(dout[1]),
        .i_core_dvld(dvld[1])
    );

    function automatic int dly_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [127:0] stub_ct(input logic [127:0] kk, input logic [127:0] pp);
        if (kk == C1_KEY && pp == C1_PT) return C1_CT;
        if (kk == B_KEY && pp == B_PT) return B_CT;
        return SW_CT;
    endfunction

    function automatic logic [7:0] ans_byte(input logic [127:0] kk, input logic [127:0] pp, input int i);
        logic [127:0] c;
        c = stub_ct(kk, pp);
        return c[127 - 8*i -: 8];
    endfunction

    // Stub core: raises dvld DV_AT cycles after leaving reset, then byte i of the
    // answer is presented so that the host samples it CAPTURE_DLY+i cycles after dvld.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (core_rst[k]) begin
                scnt[k] <= 0;
                dvld[k] <= 1'b0;
                dout[k] <= 8'h00;
            end else begin
                if (scnt[k] < 200) scnt[k] <= scnt[k] + 1;
                if (scnt[k] < 16) begin
                    kcap[k] <= {kcap[k][119:0], core_key[k]};
                    pcap[k] <= {pcap[k][119:0], core_din[k]};
                end
                if (glitch[k] && scnt[k] == 5) dvld[k] <= 1'b1;
                if (glitch[k] && scnt[k] == 6) dvld[k] <= 1'b0;
                if (!no_dvld[k] && scnt[k] == DV_AT) dvld[k] <= 1'b1;
                if (scnt[k] >= DV_AT + dly_of(k) && scnt[k] < DV_AT + dly_of(k) + 16)
                    dout[k] <= ans_byte(kcap[k], pcap[k], scnt[k] - DV_AT - dly_of(k));
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input int k, input logic [127:0] kk, input logic [127:0] pp);
        int n;
        n = 0;
        key[k] = kk;
        pt[k] = pp;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 128'(in_ready[k]), 128'(1));
    endtask

    task automatic xact(input int k, input logic [127:0] kk, input logic [127:0] pp,
                        input logic [127:0] exp_ct, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        accept(k, kk, pp);
        do begin
            @(negedge clk);
            in_valid[k] = 1'b0;
            lat++;
            if (lat == 1) begin
                chk({tag, "_busy"}, 128'({busy[k], in_ready[k], core_rst[k]}), 128'(3'b100));
            end
            if (lat <= 16) begin
                chk({tag, "_core_key"}, 128'(core_key[k]), 128'(kk[127 - 8*(lat-1) -: 8]));
                chk({tag, "_core_din"}, 128'(core_din[k]), 128'(pp[127 - 8*(lat-1) -: 8]));
            end
        end while (!out_valid[k] && lat < 200);
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_ct"}, ct[k], exp_ct);
        chk({tag, "_key_seen"}, kcap[k], kk);
        chk({tag, "_pt_seen"}, pcap[k], pp);
    endtask

    task automatic pop(input int k);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk("pop_idle", 128'({in_ready[k], out_valid[k], core_rst[k]}), 128'(3'b101));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, first, ov_seen;
        logic rst_at, rdy_at;
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        key = '0;
        pt = '0;
        no_dvld = '0;
        glitch = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(2'b11));
        chk("rst_core_rst", 128'(core_rst), 128'(2'b11));
        chk("rst_out_valid", 128'(out_valid[0]), 128'(0));
        chk("rst_err", 128'(err[0]), 128'(0));
        chk("rst_busy", 128'(busy[0]), 128'(0));
        chk("rst_ct", ct[0], 128'(0));
        chk("rst_core_bytes", 128'({core_key[0], core_din[0]}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 C.1, then a second request waits while the result is held
        xact(0, C1_KEY, C1_PT, C1_CT, 38, "c1");
        key[0] = B_KEY;
        pt[0] = B_PT;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("hold_ct", ct[0], C1_CT);
            chk("hold_flags", 128'({in_ready[0], out_valid[0], core_rst[0]}), 128'(3'b011));
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("b2b_idle", 128'({in_ready[0], out_valid[0]}), 128'(2'b10));
        xact(0, B_KEY, B_PT, B_CT, 38, "fips_b");
        pop(0);

        // Timeout: dvld never rises, TIMEOUT=20
        no_dvld[0] = 1'b1;
        accept(0, C1_KEY, C1_PT);
        pulses = 0;
        first = -1;
        ov_seen = 0;
        rst_at = 1'b0;
        rdy_at = 1'b0;
        for (int idx = 1; idx <= 60; idx++) begin
            @(negedge clk);
            in_valid[0] = 1'b0;
            if (err[0]) begin
                pulses++;
                if (first < 0) first = idx;
            end
            if (out_valid[0]) ov_seen++;
            if (idx == 37) begin
                rst_at = core_rst[0];
                rdy_at = in_ready[0];
            end
        end
        chk("tmo_pulses", 128'(pulses), 128'(1));
        chk("tmo_when", 128'(first), 128'(37));
        chk("tmo_no_out_valid", 128'(ov_seen), 128'(0));
        chk("tmo_idle", 128'({rst_at, rdy_at}), 128'(2'b11));
        no_dvld[0] = 1'b0;

        // Reset while LOAD is presenting byte 7
        accept(0, C1_KEY, C1_PT);
        repeat (8) begin
            @(negedge clk);
            in_valid[0] = 1'b0;
        end
        chk("mid_load_byte7", 128'({core_key[0], core_din[0]}), 128'(16'h0777));
        rst_n = 1'b0;
        #1;
        chk("mrst_flags", 128'({in_ready[0], core_rst[0], out_valid[0], err[0], busy[0]}),
            128'(5'b11000));
        chk("mrst_ct", ct[0], 128'(0));
        chk("mrst_core_bytes", 128'({core_key[0], core_din[0]}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(0, C1_KEY, C1_PT, C1_CT, 38, "c1_after_rst");
        pop(0);

        // Capture-delay sweep; the D=1 run also sees a dvld blip during LOAD
        glitch[0] = 1'b1;
        xact(0, 128'(0), 128'(0), SW_CT, 38, "dly1");
        pop(0);
        glitch[0] = 1'b0;
        xact(1, 128'(0), 128'(0), SW_CT, 40, "dly3");
        pop(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
